// File: rtl/spike_aer_encoder_pkg.sv
// Shared types and constants for the spike AER encoder.
// Contains the output FSM states, the spike bit position and the AER word width.
package spike_aer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } aer_state_t;

    localparam int SPIKE_BIT = 6;

    function automatic int aer_word_width(input int ts_w, input int addr_w);
        return ts_w + addr_w;
    endfunction

endpackage

// File: rtl/spike_aer_encoder_if.sv
// 4-phase AER link: the encoder is master (req/addr), the receiver is slave (ack).
// The ack is asynchronous to the encoder clock.
interface spike_aer_encoder_if #(
    parameter int AER_W = 16
);
    logic             aer_req;
    logic             aer_ack;
    logic [AER_W-1:0] aer_addr;

    modport master (output aer_req, output aer_addr, input aer_ack);
    modport slave  (input aer_req, input aer_addr, output aer_ack);
endinterface

// File: rtl/spike_aer_encoder_sync_fifo.sv
// Single-clock FIFO with wrap-bit binary pointers; read data is the current head (combinational).
// Push while full is only taken when a pop happens in the same cycle; pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [PW:0]      count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign count     = r_wr_ptr - r_rd_ptr;
    assign full      = (count == (PW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign rdata     = r_mem[r_rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
        end
    end

    // When full, push and pop share a slot: the head is read out before the edge overwrites it.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= wdata;
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Tags neuron-stage spikes with {timestep, address}, buffers them and sends them on a 4-phase AER link.
// FIFO written one edge after the spike bit; spike_allow withdraws permission while fewer than two slots are free.
module spike_aer_encoder
    import spike_aer_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int TS_WIDTH   = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DROP_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  upd_valid,
    input  logic [ADDR_WIDTH-1:0] neur_addr,
    input  logic [6:0]            event_out_in,
    input  logic                  timestep_tick,
    input  logic                  ovf_clr,
    output logic                  spike_allow,
    spike_aer_encoder_if.master   aer,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  overflow,
    output logic [DROP_WIDTH-1:0] drop_cnt
);
    localparam int AER_W = aer_word_width(TS_WIDTH, ADDR_WIDTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] r_addr_d1;
    logic                  r_vld_d1;
    logic [TS_WIDTH-1:0]   r_ts;
    logic [1:0]            r_ack_sync;
    aer_state_t            r_state;
    logic                  r_aer_req;
    logic [AER_W-1:0]      r_aer_addr;
    logic                  r_overflow;
    logic [DROP_WIDTH-1:0] r_drop_cnt;

    logic                  w_spike;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_ack_s;
    logic [AER_W-1:0]      w_rdata;
    logic [CNT_W-1:0]      w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_unused_ev;

    assign w_unused_ev = ^event_out_in[5:0];
    assign w_spike     = r_vld_d1 & event_out_in[SPIKE_BIT];
    assign w_pop       = (r_state == ST_IDLE) & ~w_empty;
    assign w_drop      = w_spike & w_full & ~w_pop;
    assign w_ack_s     = r_ack_sync[1];

    sync_fifo #(.WIDTH(AER_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (w_spike),
        .wdata ({r_ts, r_addr_d1}),
        .pop   (w_pop),
        .rdata (w_rdata),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // One slot stays reserved for the spike already in flight from the neuron stage.
    assign spike_allow  = (w_count <= CNT_W'(FIFO_DEPTH - 2));
    assign fifo_full    = w_full;
    assign fifo_empty   = w_empty;
    assign overflow     = r_overflow;
    assign drop_cnt     = r_drop_cnt;
    assign aer.aer_req  = r_aer_req;
    assign aer.aer_addr = r_aer_addr;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_addr_d1  <= '0;
            r_vld_d1   <= 1'b0;
            r_ts       <= '0;
            r_ack_sync <= 2'b00;
        end else begin
            r_addr_d1  <= neur_addr;
            r_vld_d1   <= upd_valid;
            r_ack_sync <= {r_ack_sync[0], aer.aer_ack};
            if (timestep_tick) r_ts <= r_ts + TS_WIDTH'(1);
        end
    end

    // A drop in the same cycle as a clear restarts the count at one.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (ovf_clr)                r_drop_cnt <= DROP_WIDTH'(1);
            else if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_WIDTH'(1);
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_IDLE;
            r_aer_req  <= 1'b0;
            r_aer_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_aer_addr <= w_rdata;
                        r_aer_req  <= 1'b1;
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_ack_s) begin
                        r_aer_req <= 1'b0;
                        r_state   <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!w_ack_s) r_state <= ST_IDLE;
                end
                default: begin
                    r_aer_req <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Scoreboard bench for spike_aer_encoder: expected AER words are queued when spikes are driven
// and compared as the encoder presents them on the link.
`timescale 1ns/1ps
module tb_spike_aer_encoder;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       upd_valid;
    logic [7:0] neur_addr;
    logic [6:0] event_out_in;
    logic       timestep_tick;
    logic       ovf_clr;
    logic       spike_allow;
    logic       fifo_empty;
    logic       fifo_full;
    logic       overflow;
    logic [7:0] drop_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] sb [$];

    spike_aer_encoder_if #(.AER_W(16)) aer_if ();

    spike_aer_encoder #(
        .ADDR_WIDTH (8),
        .TS_WIDTH   (8),
        .FIFO_DEPTH (16),
        .DROP_WIDTH (8)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .upd_valid     (upd_valid),
        .neur_addr     (neur_addr),
        .event_out_in  (event_out_in),
        .timestep_tick (timestep_tick),
        .ovf_clr       (ovf_clr),
        .spike_allow   (spike_allow),
        .aer           (aer_if),
        .fifo_empty    (fifo_empty),
        .fifo_full     (fifo_full),
        .overflow      (overflow),
        .drop_cnt      (drop_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST_N = 1'b0;
        upd_valid = 1'b0;
        neur_addr = '0;
        event_out_in = '0;
        timestep_tick = 1'b0;
        ovf_clr = 1'b0;
        aer_if.aer_ack = 1'b0;
        sb.delete();
        tick();
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    // Update at one edge, spike bit at the next; optionally queue the expected AER word.
    task automatic spike(input logic [7:0] a, input logic tsb, input logic [15:0] expw, input bit queue_it);
        upd_valid = 1'b1;
        neur_addr = a;
        tick();
        upd_valid = 1'b0;
        event_out_in = 7'h40;
        timestep_tick = tsb;
        if (queue_it) sb.push_back(expw);
        tick();
        event_out_in = '0;
        timestep_tick = 1'b0;
    endtask

    // Full 4-phase receive of one word, checking value, stability and req-fall latency.
    task automatic recv(input string tag);
        int          w;
        int          lat;
        bit          unstable;
        logic [15:0] expw;
        w = 0;
        while (aer_if.aer_req !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        n_tests++;
        if (aer_if.aer_req !== 1'b1) begin
            n_fail++;
            $display("FAIL %s req_timeout: aer_req=%b required 1", tag, aer_if.aer_req);
            return;
        end
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected_word: aer_addr=%h with empty scoreboard", tag, aer_if.aer_addr);
            expw = aer_if.aer_addr;
        end else begin
            expw = sb.pop_front();
            if (aer_if.aer_addr !== expw) begin
                n_fail++;
                $display("FAIL %s aer_addr: got %h required %h", tag, aer_if.aer_addr, expw);
            end
        end
        aer_if.aer_ack = 1'b1;
        lat = 0;
        unstable = 1'b0;
        while (aer_if.aer_req === 1'b1 && lat < 10) begin
            if (aer_if.aer_addr !== expw) unstable = 1'b1;
            tick();
            lat++;
        end
        n_tests++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL %s req_fall_latency: got %0d edges required 3", tag, lat);
        end
        n_tests++;
        if (unstable) begin
            n_fail++;
            $display("FAIL %s addr_stable: aer_addr changed during request, required %h", tag, expw);
        end
        aer_if.aer_ack = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if ({aer_if.aer_req, fifo_empty, fifo_full, spike_allow, overflow} !== 5'b01010) begin
            n_fail++;
            $display("FAIL reset_flags: req/empty/full/allow/ovf=%b required 01010",
                     {aer_if.aer_req, fifo_empty, fifo_full, spike_allow, overflow});
        end
        n_tests++;
        if (aer_if.aer_addr !== 16'h0000 || drop_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_values: aer_addr=%h drop_cnt=%h required 0000 00", aer_if.aer_addr, drop_cnt);
        end
    endtask

    task automatic test_single_spike();
        apply_reset();
        upd_valid = 1'b1;
        neur_addr = 8'h2A;
        tick();
        upd_valid = 1'b0;
        event_out_in = 7'h40;
        sb.push_back(16'h002A);
        tick();
        event_out_in = '0;
        n_tests++;
        if (fifo_empty !== 1'b0 || aer_if.aer_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_e1: empty=%b req=%b required 0 0", fifo_empty, aer_if.aer_req);
        end
        tick();
        n_tests++;
        if (aer_if.aer_req !== 1'b1) begin
            n_fail++;
            $display("FAIL single_e2_req: aer_req=%b required 1", aer_if.aer_req);
        end
        recv("single");
        n_tests++;
        if (fifo_empty !== 1'b1 || aer_if.aer_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: empty=%b req=%b required 1 0", fifo_empty, aer_if.aer_req);
        end
        // Spike bit without a paired update must be ignored.
        event_out_in = 7'h40;
        tick();
        event_out_in = '0;
        tick();
        n_tests++;
        if (fifo_empty !== 1'b1 || aer_if.aer_req !== 1'b0) begin
            n_fail++;
            $display("FAIL unpaired_spike: empty=%b req=%b required 1 0", fifo_empty, aer_if.aer_req);
        end
    endtask

    task automatic test_timestep();
        apply_reset();
        repeat (3) begin
            timestep_tick = 1'b1;
            tick();
            timestep_tick = 1'b0;
            tick();
        end
        spike(8'h05, 1'b1, 16'h0305, 1'b1);
        recv("ts_same_cycle_tick");
        spike(8'h11, 1'b0, 16'h0411, 1'b1);
        recv("ts_after_tick");
        timestep_tick = 1'b1;
        repeat (252) tick();
        timestep_tick = 1'b0;
        spike(8'h22, 1'b0, 16'h0022, 1'b1);
        recv("ts_wrap");
    endtask

    task automatic test_flow_control();
        logic       pend;
        logic [7:0] pend_addr;
        int         pushes;
        bit         drove;
        apply_reset();
        spike(8'hF0, 1'b0, 16'h00F0, 1'b1);
        tick();
        n_tests++;
        if (aer_if.aer_req !== 1'b1) begin
            n_fail++;
            $display("FAIL flow_blocker_req: aer_req=%b required 1", aer_if.aer_req);
        end
        pend = 1'b0;
        pend_addr = '0;
        pushes = 0;
        for (int k = 0; k < 20; k++) begin
            n_tests++;
            if (spike_allow !== (pushes <= 14)) begin
                n_fail++;
                $display("FAIL flow_allow: count=%0d spike_allow=%b required %b", pushes, spike_allow, (pushes <= 14));
            end
            drove = pend;
            event_out_in = pend ? 7'h40 : 7'h00;
            if (pend) sb.push_back({8'h00, pend_addr});
            pend = spike_allow;
            pend_addr = 8'(k);
            upd_valid = 1'b1;
            neur_addr = 8'(k);
            tick();
            if (drove) pushes++;
        end
        upd_valid = 1'b0;
        event_out_in = pend ? 7'h40 : 7'h00;
        if (pend) sb.push_back({8'h00, pend_addr});
        tick();
        if (pend) pushes++;
        event_out_in = '0;
        n_tests++;
        if (pushes != 16) begin
            n_fail++;
            $display("FAIL flow_spikes: got %0d spikes required 16", pushes);
        end
        n_tests++;
        if ({fifo_full, overflow, spike_allow} !== 3'b100 || drop_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL flow_full: full/ovf/allow=%b drop_cnt=%h required 100 00",
                     {fifo_full, overflow, spike_allow}, drop_cnt);
        end
        repeat (17) recv("flow_drain");
        n_tests++;
        if (fifo_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL flow_drained: fifo_empty=%b required 1", fifo_empty);
        end
    endtask

    task automatic test_forced_drop();
        apply_reset();
        spike(8'hEE, 1'b0, 16'h00EE, 1'b1);
        tick();
        for (int k = 0; k <= 20; k++) begin
            event_out_in = (k > 0) ? 7'h40 : 7'h00;
            if (k > 0 && k <= 16) sb.push_back(16'(k - 1));
            upd_valid = (k < 20);
            neur_addr = 8'(k);
            tick();
        end
        upd_valid = 1'b0;
        event_out_in = '0;
        n_tests++;
        if (drop_cnt !== 8'd4 || overflow !== 1'b1 || fifo_full !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_count: drop_cnt=%0d ovf=%b full=%b required 4 1 1", drop_cnt, overflow, fifo_full);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_tests++;
        if (drop_cnt !== 8'd0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_clear: drop_cnt=%0d ovf=%b required 0 0", drop_cnt, overflow);
        end
        upd_valid = 1'b1;
        neur_addr = 8'h99;
        tick();
        upd_valid = 1'b0;
        event_out_in = 7'h40;
        ovf_clr = 1'b1;
        tick();
        event_out_in = '0;
        ovf_clr = 1'b0;
        n_tests++;
        if (drop_cnt !== 8'd1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_wins_clear: drop_cnt=%0d ovf=%b required 1 1", drop_cnt, overflow);
        end
        upd_valid = 1'b1;
        event_out_in = 7'h40;
        repeat (300) tick();
        upd_valid = 1'b0;
        event_out_in = '0;
        tick();
        n_tests++;
        if (drop_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL drop_saturate: drop_cnt=%h required ff", drop_cnt);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        repeat (17) recv("drop_drain");
        n_tests++;
        if (fifo_empty !== 1'b1 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_drained: empty=%b ovf=%b required 1 0", fifo_empty, overflow);
        end
    endtask

    task automatic test_push_pop_full();
        logic [15:0] expw;
        apply_reset();
        spike(8'hB0, 1'b0, 16'h00B0, 1'b1);
        tick();
        for (int k = 0; k <= 16; k++) begin
            event_out_in = (k > 0) ? 7'h40 : 7'h00;
            if (k > 0) sb.push_back(16'(k - 1));
            upd_valid = (k < 16);
            neur_addr = 8'(k);
            tick();
        end
        upd_valid = 1'b0;
        event_out_in = '0;
        expw = sb.pop_front();
        n_tests++;
        if (fifo_full !== 1'b1 || aer_if.aer_addr !== expw) begin
            n_fail++;
            $display("FAIL pp_setup: full=%b aer_addr=%h required 1 %h", fifo_full, aer_if.aer_addr, expw);
        end
        aer_if.aer_ack = 1'b1;
        tick();
        tick();
        tick();
        aer_if.aer_ack = 1'b0;
        tick();
        tick();
        upd_valid = 1'b1;
        neur_addr = 8'h77;
        tick();
        n_tests++;
        if (aer_if.aer_req !== 1'b0) begin
            n_fail++;
            $display("FAIL pp_req_early: aer_req=%b required 0 three edges after ack fall", aer_if.aer_req);
        end
        upd_valid = 1'b0;
        event_out_in = 7'h40;
        sb.push_back(16'h0077);
        tick();
        event_out_in = '0;
        n_tests++;
        if ({aer_if.aer_req, fifo_full, overflow} !== 3'b110 || drop_cnt !== 8'h00) begin
            n_fail++;
            $display("FAIL pp_at_full: req/full/ovf=%b drop_cnt=%h required 110 00",
                     {aer_if.aer_req, fifo_full, overflow}, drop_cnt);
        end
        repeat (16) recv("pp_drain");
    endtask

    task automatic test_reset_mid();
        bit stale;
        apply_reset();
        spike(8'h31, 1'b0, 16'h0031, 1'b0);
        spike(8'h32, 1'b0, 16'h0032, 1'b0);
        n_tests++;
        if (aer_if.aer_req !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: aer_req=%b required 1", aer_if.aer_req);
        end
        RST_N = 1'b0;
        #1;
        n_tests++;
        if ({aer_if.aer_req, fifo_empty, spike_allow} !== 3'b011 || aer_if.aer_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_async_reset: req/empty/allow=%b aer_addr=%h required 011 0000",
                     {aer_if.aer_req, fifo_empty, spike_allow}, aer_if.aer_addr);
        end
        tick();
        tick();
        RST_N = 1'b1;
        stale = 1'b0;
        repeat (6) begin
            tick();
            if (aer_if.aer_req !== 1'b0 || fifo_empty !== 1'b1) stale = 1'b1;
        end
        n_tests++;
        if (stale) begin
            n_fail++;
            $display("FAIL mid_stale: req=%b empty=%b required 0 1 after release", aer_if.aer_req, fifo_empty);
        end
    endtask

    initial begin
        test_reset();
        test_single_spike();
        test_timestep();
        test_flow_control();
        test_forced_drop();
        test_push_pop_full();
        test_reset_mid();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d words never seen, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_aer_encoder.md
# spike_aer_encoder

Downstream neighbour of the LIF/Izhikevich neuron state-update stage. It pairs each neuron update with the spike bit that stage returns one cycle later. Resulting spikes are tagged with neuron address and timestep and buffered in a FIFO. They leave the core on a 4-phase AER req/ack link. The block also drives the spike-permission input of the neuron stage (its `pre_empty`) so that a spike is never generated when the FIFO has no room for it.

## Interface
Parameters:
- `ADDR_WIDTH`, 8 — neuron address width.
- `TS_WIDTH`, 8 — timestep tag width.
- `FIFO_DEPTH`, 16 — entries, power of two, ≥4.
- `DROP_WIDTH`, 8 — dropped-spike counter width.

Ports:
- `CLK` in 1 — single clock.
- `RST_N` in 1 — asynchronous, active-low reset.
- `upd_valid` in 1 — neuron update issued to the neuron stage this cycle.
- `neur_addr` in ADDR_WIDTH — address of that neuron.
- `event_out_in` in 7 — neuron-stage `event_out`; bit 6 = spike, valid one cycle after `upd_valid`.
- `timestep_tick` in 1 — one-cycle pulse ending the current timestep.
- `ovf_clr` in 1 — synchronous clear of `overflow` and `drop_cnt`.
- `spike_allow` out 1 — drives the neuron stage's `pre_empty`.
- `aer_req` out 1 — AER request.
- `aer_ack` in 1 — AER acknowledge, asynchronous to CLK.
- `aer_addr` out TS_WIDTH+ADDR_WIDTH — {timestep, neuron address}.
- `fifo_empty` out 1 — FIFO empty status.
- `fifo_full` out 1 — FIFO full status.
- `overflow` out 1 — sticky flag: a spike was dropped.
- `drop_cnt` out DROP_WIDTH — saturating count of dropped spikes.

## Operation
- **Address pairing:** on every edge, `neur_addr` and `upd_valid` are registered into `addr_d1`/`vld_d1`. A spike is accepted when `vld_d1 & event_out_in[6]`. Spikes without `vld_d1` are ignored.
- **Timestep counter:** `ts` increments on `timestep_tick` and wraps from 2^TS_WIDTH−1 to 0.
- **Spike tagging:** a spike is tagged with the value of `ts` before any same-cycle tick.
- **Push:** the write word is {ts, addr_d1}.
- **Full FIFO:**
  - If the FIFO is full and no pop occurs that cycle, the spike is dropped: `overflow` sets and `drop_cnt` increments, saturating at all-ones.
  - A push and a pop in the same cycle are always accepted; the count is unchanged.
- **`spike_allow`** = (count ≤ FIFO_DEPTH−2), decoded from the registered count. This reserves one slot for the spike already in flight.
- **`ack_s`:** `aer_ack` passes through a 2-flop synchronizer; `ack_s` is the synchronized value.
- **Output FSM:**
  - IDLE: if FIFO not empty, pop the head, register it into `aer_addr`, set `aer_req`=1, go to REQ.
  - REQ: hold `aer_req` and `aer_addr` stable. When `ack_s`=1, clear `aer_req` and go to RELEASE.
  - RELEASE: wait for `ack_s`=0, then go to IDLE.
  - Undefined state encodings return to IDLE.
- **`ovf_clr`:** zeroes `overflow` and `drop_cnt`. If a drop happens in the same cycle, the drop wins: `overflow`=1 and `drop_cnt`=1.

## Timing
- **Reset values:**
  - Outputs: `aer_req`=0, `aer_addr`=0, `fifo_empty`=1, `fifo_full`=0, `spike_allow`=1, `overflow`=0, `drop_cnt`=0.
  - Internal state: `ts`=0, FSM in IDLE, pointers 0, synchronizer 0.
- **Reset mid-operation:** `RST_N` low drops `aer_req` immediately (asynchronously) and discards FIFO contents, including an entry in handshake.
- **Pairing latency:** `upd_valid` sampled at edge E0 → spike sampled at E1 → FIFO written at E1.
- **Output latency:**
  - With the FIFO empty and the FSM in IDLE, `aer_req` rises at E2.
  - Req-to-release: `aer_req` falls 3 edges after `aer_ack` rises (2 synchronizer edges + 1 FSM edge).
  - The next `aer_req` can rise no earlier than 3 edges after `aer_ack` falls.
- **Throughput:** one spike push per cycle sustained; AER output limited by the handshake.
- **Status update:** `fifo_full`/`fifo_empty` reflect the count registered at the preceding edge.

## Structure
- **Package `spike_aer_pkg`:**
  - FSM state enum (IDLE, REQ, RELEASE).
  - Spike bit index constant (6).
  - AER word width function.
- **Sub-module `sync_fifo`:**
  - Parameterised width/depth.
  - Binary pointers with one extra wrap bit.
  - Outputs count, full, empty; supports push and pop in the same cycle.
- **Top level:** pairing registers, `ts` counter, drop logic, synchronizer and FSM.

## Test plan
- **Single spike:** reset; `upd_valid`=1, `neur_addr`=0x2A at E0; `event_out_in`=0x40 at E1 → `aer_req` rises at E2 with `aer_addr`=0x002A. Ack the 4-phase cycle → `aer_req` falls 3 edges after ack, `fifo_empty`=1.
- **Timestep tag:** 3 `timestep_tick` pulses, then a spike at address 0x05 coinciding with a 4th tick → `aer_addr`=0x0305. Next spike → 0x04xx. After 256 ticks from reset, `ts` wraps to 0.
- **Flow control:** hold `aer_ack`=0 and push spikes every cycle → `spike_allow` falls when count reaches 15. An in-flight spike fills entry 16 (`fifo_full`=1) and `overflow` stays 0.
- **Forced drop:** ignore `spike_allow` and push 20 spikes into a stalled FIFO → `drop_cnt`=4, `overflow`=1. Assert `ovf_clr` → both 0. Entries read out in order 0..15.
- **Push/pop at full:** FIFO full, FSM in IDLE popping, spike arriving the same cycle → no drop, count stays 16.
- **Reset mid-handshake:** assert `RST_N`=0 while `aer_req`=1 → `aer_req`=0 within the same cycle, FIFO empty, `spike_allow`=1. After release, no stale request appears.
